calc_key_ctrl: RTL and testbench

//  Sequencer behind the calculator keypad display. It takes debounced navigation/select

---
 rtl/calc_key_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 tb/tb_calc_key_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_ctrl.sv
// Calculator keypad sequencer: moves a 4x4 cursor, edits an expression buffer and
// evaluates it with '*' binding tighter than '+'/'-'. Multiplication is a serial
// shift-add over RES_W cycles.
// Optional feature macro: OVF_DETECT_EN (flag arithmetic overflow as an error).
module calc_key_ctrl #(
  parameter int unsigned MAX_CHARS = 32,
  parameter int unsigned RES_W     = 32
) (
  input  logic                   clk_in,
  input  logic                   sys_rst,
  input  logic                   key_up,
  input  logic                   key_down,
  input  logic                   key_left,
  input  logic                   key_right,
  input  logic                   key_sel,
  output logic [3:0]             cursor_x,
  output logic [3:0]             cursor_y,
  output logic [MAX_CHARS*8-1:0] disp_str_flat,
  output logic [RES_W-1:0]       result,
  output logic                   calc_done,
  output logic                   busy,
  output logic                   err
);

`ifdef OVF_DETECT_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  localparam int unsigned IW = $clog2(MAX_CHARS);
  localparam int unsigned LW = $clog2(MAX_CHARS + 1);
  localparam int unsigned CW = $clog2(RES_W);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StEval = 2'd1;
  localparam logic [1:0] StMul  = 2'd2;
  localparam logic [1:0] StFin  = 2'd3;

  // Action to perform once a term has been closed
  localparam logic [1:0] PendAdd = 2'd0;
  localparam logic [1:0] PendSub = 2'd1;
  localparam logic [1:0] PendMul = 2'd2;
  localparam logic [1:0] PendEnd = 2'd3;

  localparam logic [7:0] ChSpace = 8'h20;
  localparam logic [7:0] ChPlus  = 8'h2B;
  localparam logic [7:0] ChMinus = 8'h2D;
  localparam logic [7:0] ChEq    = 8'h3D;
  localparam logic [7:0] ChB     = 8'h42;
  localparam logic [7:0] ChC     = 8'h43;

  function automatic logic [7:0] key_char(input logic [1:0] row, input logic [1:0] col);
    logic [7:0] ch;
    case ({row, col})
      4'd0:    ch = 8'h31;
      4'd1:    ch = 8'h32;
      4'd2:    ch = 8'h33;
      4'd3:    ch = ChPlus;
      4'd4:    ch = 8'h34;
      4'd5:    ch = 8'h35;
      4'd6:    ch = 8'h36;
      4'd7:    ch = ChMinus;
      4'd8:    ch = 8'h37;
      4'd9:    ch = 8'h38;
      4'd10:   ch = 8'h39;
      4'd11:   ch = 8'h2A;
      4'd12:   ch = ChC;
      4'd13:   ch = 8'h30;
      4'd14:   ch = ChEq;
      default: ch = ChB;
    endcase
    return ch;
  endfunction

  function automatic logic [1:0] op_pend(input logic [7:0] ch);
    if (ch == ChPlus)       return PendAdd;
    else if (ch == ChMinus) return PendSub;
    else                    return PendMul;
  endfunction

  // Top bit of the result is the carry (add) or borrow (subtract)
  function automatic logic [RES_W:0] acc(input logic [RES_W-1:0] s, input logic [RES_W-1:0] t,
                                         input logic sub);
    return sub ? ({1'b0, s} - {1'b0, t}) : ({1'b0, s} + {1'b0, t});
  endfunction

  logic [1:0]       state_q, state_d;
  logic [1:0]       cx_q, cx_d, cy_q, cy_d;
  logic [7:0]       chars_q [MAX_CHARS];
  logic [7:0]       chars_d [MAX_CHARS];
  logic [LW-1:0]    len_q, len_d, idx_q, idx_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             calc_done_q, calc_done_d, err_q, err_d;
  logic [RES_W-1:0] sum_q, sum_d, term_q, term_d, num_q, num_d;
  logic             neg_q, neg_d, mulp_q, mulp_d, prev_op_q, prev_op_d;
  logic             syn_err_q, syn_err_d, ovf_q, ovf_d;
  logic [RES_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_p_q, mul_p_d;
  logic [CW-1:0]    mul_cnt_q, mul_cnt_d;
  logic [1:0]       pend_q, pend_d;

  logic [7:0]       key_ch, cur_c;
  logic             cur_dig, cur_last;
  logic [RES_W+3:0] num_ext;
  logic [LW-1:0]    wr_base, bs_idx;
  logic [RES_W:0]   mul_add, acc_v;
  logic             apply_en;
  logic [RES_W-1:0] apply_t;
  logic [1:0]       apply_pend;

  assign key_ch   = key_char(cy_q, cx_q);
  assign cur_c    = chars_q[idx_q[IW-1:0]];
  assign cur_dig  = (cur_c >= 8'h30) && (cur_c <= 8'h39);
  assign cur_last = (idx_q == len_q - 1'b1);
  assign num_ext  = {4'b0000, num_q} * (RES_W+4)'(10) + {{RES_W{1'b0}}, cur_c[3:0]};
  assign wr_base  = calc_done_q ? '0 : len_q;
  assign bs_idx   = len_q - 1'b1;

  assign cursor_x  = {2'b00, cx_q};
  assign cursor_y  = {2'b00, cy_q};
  assign result    = result_q;
  assign calc_done = calc_done_q;
  assign err       = err_q;
  assign busy      = (state_q != StIdle);

  for (genvar k = 0; k < MAX_CHARS; k++) begin : g_disp
    assign disp_str_flat[k*8 +: 8] = chars_q[k];
  end

  // Next-state logic: key handling in idle, expression scan, serial multiply, finish
  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    chars_d     = chars_q;
    len_d       = len_q;
    idx_d       = idx_q;
    result_d    = result_q;
    calc_done_d = calc_done_q;
    err_d       = err_q;
    sum_d       = sum_q;
    term_d      = term_q;
    num_d       = num_q;
    neg_d       = neg_q;
    mulp_d      = mulp_q;
    prev_op_d   = prev_op_q;
    syn_err_d   = syn_err_q;
    ovf_d       = ovf_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_p_d     = mul_p_q;
    mul_cnt_d   = mul_cnt_q;
    pend_d      = pend_q;
    mul_add     = '0;
    acc_v       = '0;
    apply_en    = 1'b0;
    apply_t     = '0;
    apply_pend  = PendEnd;

    case (state_q)
      StIdle: begin
        if (key_sel) begin
          case (key_ch)
            ChC: begin
              for (int unsigned k = 0; k < MAX_CHARS; k++) chars_d[k] = ChSpace;
              len_d       = '0;
              calc_done_d = 1'b0;
              err_d       = 1'b0;
              result_d    = '0;
            end
            ChB: begin
              if (len_q != '0) begin
                chars_d[bs_idx[IW-1:0]] = ChSpace;
                len_d                   = bs_idx;
                calc_done_d             = 1'b0;
              end
            end
            ChEq: begin
              if (len_q != '0) begin
                state_d     = StEval;
                idx_d       = '0;
                calc_done_d = 1'b0;
                sum_d       = '0;
                term_d      = '0;
                num_d       = '0;
                neg_d       = 1'b0;
                mulp_d      = 1'b0;
                prev_op_d   = 1'b1;
                syn_err_d   = 1'b0;
                ovf_d       = 1'b0;
              end
            end
            default: begin
              // A finished result is discarded by the first edit key
              if (calc_done_q) begin
                for (int unsigned k = 0; k < MAX_CHARS; k++) chars_d[k] = ChSpace;
                calc_done_d = 1'b0;
                err_d       = 1'b0;
              end
              if (wr_base != LW'(MAX_CHARS)) begin
                chars_d[wr_base[IW-1:0]] = key_ch;
                len_d                    = wr_base + 1'b1;
              end
            end
          endcase
        end else if (key_up) begin
          cy_d = cy_q - 1'b1;
        end else if (key_down) begin
          cy_d = cy_q + 1'b1;
        end else if (key_left) begin
          cx_d = cx_q - 1'b1;
        end else if (key_right) begin
          cx_d = cx_q + 1'b1;
        end
      end

      StEval: begin
        idx_d = idx_q + 1'b1;
        if (cur_dig) begin
          num_d     = num_ext[RES_W-1:0];
          prev_op_d = 1'b0;
          if (OvfEn && (num_ext[RES_W+3:RES_W] != 4'd0)) ovf_d = 1'b1;
          if (cur_last) begin
            if (mulp_q) begin
              mul_a_d   = term_q;
              mul_b_d   = num_ext[RES_W-1:0];
              mul_p_d   = '0;
              mul_cnt_d = '0;
              pend_d    = PendEnd;
              state_d   = StMul;
            end else begin
              apply_en   = 1'b1;
              apply_t    = num_ext[RES_W-1:0];
              apply_pend = PendEnd;
            end
          end
        end else if (prev_op_q || cur_last) begin
          // Leading, doubled or trailing operator
          syn_err_d = 1'b1;
          state_d   = StFin;
        end else if (mulp_q) begin
          mul_a_d   = term_q;
          mul_b_d   = num_q;
          mul_p_d   = '0;
          mul_cnt_d = '0;
          pend_d    = op_pend(cur_c);
          state_d   = StMul;
        end else begin
          apply_en   = 1'b1;
          apply_t    = num_q;
          apply_pend = op_pend(cur_c);
        end
      end

      StMul: begin
        mul_add   = {1'b0, mul_p_q} + (mul_b_q[0] ? {1'b0, mul_a_q} : '0);
        mul_p_d   = mul_add[RES_W-1:0];
        mul_a_d   = mul_a_q << 1;
        mul_b_d   = mul_b_q >> 1;
        mul_cnt_d = mul_cnt_q + 1'b1;
        // Overflow if the add carries or a set multiplicand bit is shifted out while
        // higher multiplier bits remain
        if (OvfEn && (mul_add[RES_W] ||
                      (mul_a_q[RES_W-1] && (mul_b_q[RES_W-1:1] != '0)))) begin
          ovf_d = 1'b1;
        end
        if (mul_cnt_q == CW'(RES_W - 1)) begin
          state_d    = StEval;
          apply_en   = 1'b1;
          apply_t    = mul_add[RES_W-1:0];
          apply_pend = pend_q;
        end
      end

      default: begin
        result_d    = (syn_err_q || ovf_q) ? '0 : sum_q;
        err_d       = syn_err_q | ovf_q;
        calc_done_d = 1'b1;
        state_d     = StIdle;
      end
    endcase

    // Fold a closed term into the running sum or the pending product
    if (apply_en) begin
      acc_v  = acc(sum_q, apply_t, neg_q);
      term_d = apply_t;
      case (apply_pend)
        PendMul: begin
          mulp_d    = 1'b1;
          num_d     = '0;
          prev_op_d = 1'b1;
        end
        PendEnd: begin
          sum_d   = acc_v[RES_W-1:0];
          if (OvfEn && acc_v[RES_W]) ovf_d = 1'b1;
          state_d = StFin;
        end
        default: begin
          sum_d     = acc_v[RES_W-1:0];
          if (OvfEn && acc_v[RES_W]) ovf_d = 1'b1;
          neg_d     = (apply_pend == PendSub);
          mulp_d    = 1'b0;
          num_d     = '0;
          prev_op_d = 1'b1;
        end
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      cx_q        <= '0;
      cy_q        <= '0;
      for (int unsigned k = 0; k < MAX_CHARS; k++) chars_q[k] <= ChSpace;
      len_q       <= '0;
      idx_q       <= '0;
      result_q    <= '0;
      calc_done_q <= 1'b0;
      err_q       <= 1'b0;
      sum_q       <= '0;
      term_q      <= '0;
      num_q       <= '0;
      neg_q       <= 1'b0;
      mulp_q      <= 1'b0;
      prev_op_q   <= 1'b1;
      syn_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_p_q     <= '0;
      mul_cnt_q   <= '0;
      pend_q      <= PendEnd;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      chars_q     <= chars_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      calc_done_q <= calc_done_d;
      err_q       <= err_d;
      sum_q       <= sum_d;
      term_q      <= term_d;
      num_q       <= num_d;
      neg_q       <= neg_d;
      mulp_q      <= mulp_d;
      prev_op_q   <= prev_op_d;
      syn_err_q   <= syn_err_d;
      ovf_q       <= ovf_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_p_q     <= mul_p_d;
      mul_cnt_q   <= mul_cnt_d;
      pend_q      <= pend_d;
    end
  end

endmodule

// File: tb/tb_calc_key_ctrl.sv
// Directed bench for calc_key_ctrl: navigation, editing, evaluation, latency, reset.
module tb_calc_key_ctrl;

  localparam int KUp = 0, KDown = 1, KLeft = 2, KRight = 3, KSel = 4;

  logic         clk_in = 1'b0;
  logic         sys_rst = 1'b1;
  logic         key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic         key_sel = 1'b0;
  logic [3:0]   cursor_x, cursor_y;
  logic [255:0] disp_str_flat;
  logic [31:0]  result;
  logic         calc_done, busy, err;

  int total = 0;
  int bad   = 0;
  int cx    = 0;
  int cy    = 0;
  int n;
  logic [255:0] exp_v;

  calc_key_ctrl dut (
    .clk_in        (clk_in),
    .sys_rst       (sys_rst),
    .key_up        (key_up),
    .key_down      (key_down),
    .key_left      (key_left),
    .key_right     (key_right),
    .key_sel       (key_sel),
    .cursor_x      (cursor_x),
    .cursor_y      (cursor_y),
    .disp_str_flat (disp_str_flat),
    .result        (result),
    .calc_done     (calc_done),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      KUp:    key_up = 1'b1;
      KDown:  key_down = 1'b1;
      KLeft:  key_left = 1'b1;
      KRight: key_right = 1'b1;
      default: key_sel = 1'b1;
    endcase
    tick();
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0; key_sel = 1'b0;
  endtask

  // Walk the cursor to the key (tracked by the bench model) and select it
  task automatic press_key(input byte ch);
    string grid;
    int r, c;
    grid = "123+456-789*C0=B";
    r = cy; c = cx;
    for (int i = 0; i < 16; i++) if (grid[i] == ch) begin r = i / 4; c = i % 4; end
    while (cx != c) begin pulse(KRight); cx = (cx + 1) % 4; end
    while (cy != r) begin pulse(KDown); cy = (cy + 1) % 4; end
    pulse(KSel);
  endtask

  task automatic type_str(input string s);
    for (int k = 0; k < s.len(); k++) press_key(s[k]);
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!calc_done && cnt < 300);
    chk("done_seen", {255'd0, calc_done}, 256'd1);
  endtask

  function automatic logic [255:0] disp_of(input string s);
    logic [255:0] v;
    v = {32{8'h20}};
    for (int k = 0; k < s.len(); k++) v[k*8 +: 8] = s[k];
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_cx", cursor_x, 0);
    chk("rst_cy", cursor_y, 0);
    chk("rst_disp", disp_str_flat, {32{8'h20}});
    chk("rst_result", result, 0);
    chk("rst_done", calc_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    sys_rst = 1'b0;
    tick();

    // Navigation, wrap and priority
    pulse(KRight);
    chk("nav_x1", cursor_x, 1);
    pulse(KRight); pulse(KRight); pulse(KRight);
    chk("nav_xwrap", cursor_x, 0);
    pulse(KUp);
    chk("nav_ywrap", cursor_y, 3);
    key_sel = 1'b1; key_up = 1'b1;
    tick();
    key_sel = 1'b0; key_up = 1'b0;
    chk("sel_over_up", cursor_y, 3);
    key_down = 1'b1; key_left = 1'b1;
    tick();
    key_down = 1'b0; key_left = 1'b0;
    chk("down_over_left_y", cursor_y, 0);
    chk("down_over_left_x", cursor_x, 0);
    key_left = 1'b1; key_right = 1'b1;
    tick();
    key_left = 1'b0; key_right = 1'b0;
    chk("left_over_right", cursor_x, 3);
    cx = 3; cy = 0;

    // 12+3 = 15, calc_done on 5th edge after '='
    type_str("12+3");
    chk("disp_12p3", disp_str_flat, disp_of("12+3"));
    press_key("=");
    chk("eval_busy", busy, 1);
    wait_done(n);
    chk("lat_12p3", n, 5);
    chk("busy_low", busy, 0);
    chk("res_15", result, 15);
    chk("err_15", err, 0);
    chk("disp_kept", disp_str_flat, disp_of("12+3"));

    // Second '=' re-evaluates
    press_key("=");
    chk("reeval_done_clr", calc_done, 0);
    wait_done(n);
    chk("reeval_15", result, 15);

    // Precedence with serial multiply
    press_key("C");
    chk("clr_result", result, 0);
    chk("clr_disp", disp_str_flat, {32{8'h20}});
    press_key("=");
    tick();
    chk("empty_eq_busy", busy, 0);
    chk("empty_eq_done", calc_done, 0);
    type_str("2+3*4");
    press_key("=");
    repeat (6) tick();
    chk("mul_busy", busy, 1);
    chk("mul_not_done", calc_done, 0);
    wait_done(n);
    chk("res_14", result, 14);
    chk("err_14", err, 0);
    press_key("5");
    chk("edit_after_done", disp_str_flat, disp_of("5"));
    chk("edit_done_clr", calc_done, 0);

    press_key("C");
    type_str("3*4+5*6-2");
    press_key("=");
    wait_done(n);
    chk("res_40", result, 40);

    // Subtraction wrap / borrow
    press_key("C");
    type_str("5-7");
    press_key("=");
    wait_done(n);
`ifdef OVF_DETECT_EN
    chk("res_5m7", result, 0);
    chk("err_5m7", err, 1);
`else
    chk("res_5m7", result, 32'hFFFF_FFFE);
    chk("err_5m7", err, 0);
`endif

    // 2^16 * 2^16 wraps to zero
    press_key("C");
    type_str("65536*65536");
    press_key("=");
    wait_done(n);
    chk("res_mulwrap", result, 0);
`ifdef OVF_DETECT_EN
    chk("err_mulwrap", err, 1);
`else
    chk("err_mulwrap", err, 0);
`endif

    // Buffer full, backspace, syntax error
    press_key("C");
    for (int k = 0; k < 33; k++) press_key("9");
    chk("full_disp", disp_str_flat, {32{8'h39}});
    press_key("B");
    chk("bs_char31", disp_str_flat[31*8 +: 8], 8'h20);
    exp_v = {8'h20, {31{8'h39}}};
    chk("bs_disp", disp_str_flat, exp_v);
    press_key("C");
    type_str("1+");
    press_key("=");
    wait_done(n);
    chk("syn_err", err, 1);
    chk("syn_res", result, 0);

    // Asynchronous reset in the middle of an evaluation
    press_key("C");
    type_str("12+3");
    press_key("=");
    tick();
    chk("pre_rst_busy", busy, 1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", calc_done, 0);
    chk("arst_cx", cursor_x, 0);
    chk("arst_cy", cursor_y, 0);
    chk("arst_disp", disp_str_flat, {32{8'h20}});
    tick();
    sys_rst = 1'b0;
    cx = 0; cy = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
